// File: rtl/addsub_pkg.sv
// ----------------------------------------------------------------------------
// addsub_pkg
//   Shared definitions for the arbitrated adder-subtractor slice.
//   ADDSUB_WIDTH : default operand/result width used by addsub_core and
//                  addsub_arbiter
//   OP_ADD/OP_SUB: encodings of the per-requester op bit (it doubles as the
//                  core carry-in C0)
//   state_t      : arbiter FSM states
// ----------------------------------------------------------------------------
package addsub_pkg;

   localparam int ADDSUB_WIDTH = 5;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/addsub_core.sv
// ----------------------------------------------------------------------------
// addsub_core
//   Combinational gate-level ripple adder-subtractor.
//   S = X + (Y xor {WIDTH{C0}}) + C0, so C0=0 adds and C0=1 subtracts.
// Ports
//   C0  in   1      carry-in / subtract select
//   X   in   WIDTH  first operand
//   Y   in   WIDTH  second operand (inverted when C0=1)
//   S   out  WIDTH  result, modulo 2^WIDTH
//   C4  out  1      carry into the MSB stage
//   C5  out  1      carry out of the MSB stage
//   E   out  1      signed overflow, C4 xor C5
// ----------------------------------------------------------------------------
module addsub_core
   import addsub_pkg::*;
#(
   parameter int WIDTH = ADDSUB_WIDTH
) (
   input  logic             C0,
   input  logic [WIDTH-1:0] X,
   input  logic [WIDTH-1:0] Y,
   output logic [WIDTH-1:0] S,
   output logic             C4,
   output logic             C5,
   output logic             E
);

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] y_eff;

   // Conditional inversion of Y plus carry-in gives two's complement subtract.
   assign y_eff    = Y ^ {WIDTH{C0}};
   assign carry[0] = C0;

   // One full adder per bit; carry ripples LSB to MSB.
   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign S[i]       = X[i] ^ y_eff[i] ^ carry[i];
      assign carry[i+1] = (X[i] & y_eff[i]) | (carry[i] & (X[i] ^ y_eff[i]));
   end

   // Overflow falls out of the disagreement between the last two carries.
   assign C4 = carry[WIDTH-1];
   assign C5 = carry[WIDTH];
   assign E  = C4 ^ C5;

endmodule

// File: rtl/addsub_arbiter.sv
// ----------------------------------------------------------------------------
// addsub_arbiter
//   Round-robin arbiter sharing one addsub_core between two requesters.
//   A request is latched in IDLE, computed in EXEC and held in RESP until the
//   consumer takes it, so at most one operation is in flight.
// Ports
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   req_valid  in   2        per-requester request valid
//   req_ready  out  2        per-requester accept (one-hot or zero)
//   req_op     in   2        per-requester op, 0=add 1=sub
//   req_x      in   2xWIDTH  X operands packed {r1,r0}
//   req_y      in   2xWIDTH  Y operands packed {r1,r0}
//   rsp_valid  out  1        response valid, held until rsp_ready
//   rsp_ready  in   1        response consumer ready
//   rsp_id     out  1        requester that owns the response
//   rsp_s      out  WIDTH    result
//   rsp_c4     out  1        carry into MSB stage
//   rsp_c5     out  1        carry out of MSB stage
//   rsp_e      out  1        overflow
// Configuration
//   ADDSUB_SAT_EN : when defined, an overflowing result saturates toward the
//                   sign of X; the carry/overflow flags stay raw.
// ----------------------------------------------------------------------------
module addsub_arbiter
   import addsub_pkg::*;
#(
   parameter int WIDTH = ADDSUB_WIDTH
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [1:0]         req_op,
   input  logic [2*WIDTH-1:0] req_x,
   input  logic [2*WIDTH-1:0] req_y,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_id,
   output logic [WIDTH-1:0]   rsp_s,
   output logic               rsp_c4,
   output logic               rsp_c5,
   output logic               rsp_e
);

   state_t           state;
   logic             rr_ptr;
   logic             grant;
   logic             any_valid;
   logic             op_q;
   logic [WIDTH-1:0] x_q;
   logic [WIDTH-1:0] y_q;
   logic             id_q;
   logic [WIDTH-1:0] core_s;
   logic             core_c4;
   logic             core_c5;
   logic             core_e;
   logic [WIDTH-1:0] result_s;

   // The requester pointed to by rr_ptr has priority; the other one is only
   // granted when the favoured one is idle, which yields strict alternation
   // under contention.
   always_comb begin
      any_valid = |req_valid;
      grant     = rr_ptr;
      if (!req_valid[rr_ptr]) begin
         grant = ~rr_ptr;
      end
   end

   // Accept is offered only while idle, and only to the granted requester.
   always_comb begin
      req_ready = 2'b00;
      if ((state == IDLE) && any_valid) begin
         req_ready[grant] = 1'b1;
      end
   end

   addsub_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .C0 (op_q == OP_SUB),
      .X  (x_q),
      .Y  (y_q),
      .S  (core_s),
      .C4 (core_c4),
      .C5 (core_c5),
      .E  (core_e)
   );

   // Result selection: saturate toward the sign of X on overflow when the
   // saturating build is chosen, otherwise pass the wrapped sum through.
   always_comb begin
      result_s = core_s;
`ifdef ADDSUB_SAT_EN
      if (core_e) begin
         result_s = x_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
      end
`endif
   end

   // Control FSM with registered operand capture and registered response.
   // The pointer flips to the loser on every accept; a response drain always
   // returns to IDLE first, so no request is taken in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= 1'b0;
         op_q      <= OP_ADD;
         x_q       <= '0;
         y_q       <= '0;
         id_q      <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_s     <= '0;
         rsp_c4    <= 1'b0;
         rsp_c5    <= 1'b0;
         rsp_e     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  op_q   <= req_op[grant];
                  x_q    <= grant ? req_x[2*WIDTH-1:WIDTH] : req_x[WIDTH-1:0];
                  y_q    <= grant ? req_y[2*WIDTH-1:WIDTH] : req_y[WIDTH-1:0];
                  id_q   <= grant;
                  rr_ptr <= ~grant;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_s     <= result_s;
               rsp_c4    <= core_c4;
               rsp_c5    <= core_c5;
               rsp_e     <= core_e;
               rsp_id    <= id_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_arbiter.sv
// ----------------------------------------------------------------------------
// tb_addsub_arbiter
//   Directed bench for addsub_arbiter. Expected responses are queued as the
//   stimulus is issued; a monitor pops and compares them whenever a response
//   handshake is seen. Honour ADDSUB_SAT_EN consistently with the RTL build.
// ----------------------------------------------------------------------------
module tb_addsub_arbiter;

   localparam int W = 5;

   typedef struct packed {
      logic         id;
      logic [W-1:0] s;
      logic         c4;
      logic         c5;
      logic         e;
   } rsp_t;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [1:0]     req_valid;
   logic [1:0]     req_ready;
   logic [1:0]     req_op;
   logic [2*W-1:0] req_x;
   logic [2*W-1:0] req_y;
   logic           rsp_valid;
   logic           rsp_ready;
   logic           rsp_id;
   logic [W-1:0]   rsp_s;
   logic           rsp_c4;
   logic           rsp_c5;
   logic           rsp_e;

   // Per-requester drive variables so concurrent requester processes never
   // write the same variable.
   logic           v0, v1, op0, op1;
   logic [W-1:0]   x0, x1, y0, y1;

   int             n_checks = 0;
   int             n_fail   = 0;
   rsp_t           exp_q[$];

   assign req_valid = {v1, v0};
   assign req_op    = {op1, op0};
   assign req_x     = {x1, x0};
   assign req_y     = {y1, y0};

   always #5 clk = ~clk;

   addsub_arbiter #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_x     (req_x),
      .req_y     (req_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_s     (rsp_s),
      .rsp_c4    (rsp_c4),
      .rsp_c5    (rsp_c5),
      .rsp_e     (rsp_e)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic flagTimeout(input string name);
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s: timed out", name);
   endtask

   task automatic pushExp(input logic id, input logic [W-1:0] s,
                          input logic c4, input logic c5, input logic e);
      rsp_t r;
      r.id = id; r.s = s; r.c4 = c4; r.c5 = c5; r.e = e;
      exp_q.push_back(r);
   endtask

   task automatic setReq(input int idx, input logic op, input logic [W-1:0] x,
                         input logic [W-1:0] y);
      if (idx == 0) begin
         v0 = 1'b1; op0 = op; x0 = x; y0 = y;
      end else begin
         v1 = 1'b1; op1 = op; x1 = x; y1 = y;
      end
   endtask

   task automatic releaseReq(input int idx);
      @(negedge clk);
      if (idx == 0) v0 = 1'b0;
      else          v1 = 1'b0;
   endtask

   // Presents a request and returns just after the edge that transfers it.
   task automatic applyStimulus(input int idx, input logic op,
                                input logic [W-1:0] x, input logic [W-1:0] y);
      bit done = 1'b0;
      @(negedge clk);
      setReq(idx, op, x, y);
      for (int i = 0; i < 50 && !done; i++) begin
         #1;
         if (req_ready[idx]) begin
            @(posedge clk);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!done) flagTimeout($sformatf("grant_r%0d", idx));
   endtask

   task automatic waitRspValid();
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      if (!seen) flagTimeout("rsp_valid");
   endtask

   task automatic waitDrain(input string name);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge clk);
      checkOutput({name, "_pending"}, exp_q.size(), 0);
   endtask

   // Monitor: protocol checks every cycle plus scoreboard pop on each
   // response handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("ready_not_both", {31'b0, &req_ready}, 32'd0);
         if (rsp_valid) checkOutput("ready_in_resp", {30'b0, req_ready}, 32'd0);
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               flagTimeout("unexpected_response");
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               checkOutput("response {id,s,c4,c5,e}",
                           {23'b0, rsp_id, rsp_s, rsp_c4, rsp_c5, rsp_e},
                           {23'b0, e});
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [W-1:0] ovf_s;
`ifdef ADDSUB_SAT_EN
      ovf_s = 5'b01111;
`else
      ovf_s = 5'b11110;
`endif
      v0 = 0; v1 = 0; op0 = 0; op1 = 0; x0 = 0; x1 = 0; y0 = 0; y1 = 0;
      rsp_ready = 1'b1;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("reset_rsp_s", {27'b0, rsp_s}, 32'd0);
      checkOutput("reset_flags", {28'b0, rsp_id, rsp_c4, rsp_c5, rsp_e}, 32'd0);
      checkOutput("reset_req_ready", {30'b0, req_ready}, 32'd0);
      @(posedge clk); #2 rst_n = 1'b1;

      // r0 add 7+5, with latency check
      pushExp(1'b0, 5'b01100, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b0, 5'd7, 5'd5);
      @(negedge clk); v0 = 1'b0; #1;
      checkOutput("latency_exec", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      checkOutput("latency_resp", {31'b0, rsp_valid}, 32'd1);

      // r1 sub 7-5
      pushExp(1'b1, 5'b00010, 1'b1, 1'b1, 1'b0);
      applyStimulus(1, 1'b1, 5'd7, 5'd5);
      releaseReq(1);

      // r0 add 15+15 overflows
      pushExp(1'b0, ovf_s, 1'b1, 1'b0, 1'b1);
      applyStimulus(0, 1'b0, 5'd15, 5'd15);
      releaseReq(0);

      // r0 sub 0-15 wraps without overflow
      pushExp(1'b0, 5'b10001, 1'b0, 1'b0, 1'b0);
      applyStimulus(0, 1'b1, 5'd0, 5'd15);
      releaseReq(0);
      waitDrain("directed");

      // Backpressure: r1 response held 5 cycles while r0 waits
      @(posedge clk); #1 rsp_ready = 1'b0;
      pushExp(1'b1, 5'b00101, 1'b0, 1'b0, 1'b0);
      applyStimulus(1, 1'b0, 5'd2, 5'd3);
      releaseReq(1);
      setReq(0, 1'b0, 5'd1, 5'd1);
      waitRspValid();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_valid", {31'b0, rsp_valid}, 32'd1);
         checkOutput("hold_s", {27'b0, rsp_s}, 32'h05);
         checkOutput("hold_id", {31'b0, rsp_id}, 32'd1);
         checkOutput("hold_req_ready", {30'b0, req_ready}, 32'd0);
      end
      pushExp(1'b0, 5'b00010, 1'b0, 1'b0, 1'b0);
      @(posedge clk); #1 rsp_ready = 1'b1;
      applyStimulus(0, 1'b0, 5'd1, 5'd1);
      releaseReq(0);
      waitDrain("backpressure");

      // Reset while a response is pending discards it
      @(posedge clk); #1 rsp_ready = 1'b0;
      applyStimulus(0, 1'b1, 5'd4, 5'd1);
      releaseReq(0);
      waitRspValid();
      @(posedge clk); #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      checkOutput("midreset_rsp_s", {27'b0, rsp_s}, 32'd0);
      checkOutput("midreset_flags", {28'b0, rsp_id, rsp_c4, rsp_c5, rsp_e}, 32'd0);
      @(negedge clk);
      @(posedge clk); #2 rst_n = 1'b1; rsp_ready = 1'b1;

      // Contention from reset: strict alternation 0,1,0,1
      pushExp(1'b0, 5'b00011, 1'b0, 1'b0, 1'b0);
      pushExp(1'b1, 5'b00110, 1'b1, 1'b1, 1'b0);
      pushExp(1'b0, 5'b00111, 1'b0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
      pushExp(1'b1, 5'b01111, 1'b1, 1'b0, 1'b1);
`else
      pushExp(1'b1, 5'b10000, 1'b1, 1'b0, 1'b1);
`endif
      fork
         begin
            applyStimulus(0, 1'b0, 5'd1, 5'd2);
            applyStimulus(0, 1'b0, 5'd3, 5'd4);
            releaseReq(0);
         end
         begin
            applyStimulus(1, 1'b1, 5'd9, 5'd3);
            applyStimulus(1, 1'b0, 5'd8, 5'd8);
            releaseReq(1);
         end
      join
      waitDrain("contention");

      repeat (2) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
